multicycle_controller: RTL

- Control unit for the MIPS multicycle CPU. It is the other end of the datapath control interface: it consumes opcode/funct from the datapath and drives every datapath select, enable and ALU control.
- Built as a Moore main FSM (one state per instruction step) plus a combinational ALU decoder.
- Sits beside the datapath in the CPU top level, sharing its clock.

---
 rtl/multicycle_controller.sv | 306 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Control unit for the MIPS multicycle CPU. A Moore main FSM
//               sequences each instruction through its steps and a
//               combinational ALU decoder turns the internal alu_op (plus
//               funct for R-type) into the 3-bit ALU control.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-high reset
//   opcode[5:0]    instr[31:26] from datapath
//   funct[5:0]     instr[5:0] from datapath
//   mem_to_reg     0 = ALUOut, 1 = memory data register to reg write data
//   reg_dest       0 = rt, 1 = rd as write register
//   i_or_d         0 = PC addresses memory, 1 = ALUOut
//   alu_src_a      0 = PC, 1 = register A
//   ir_write       instruction register load enable
//   mem_write      memory write enable
//   pc_write       unconditional PC load
//   branch         PC load qualified by datapath zero
//   reg_write      register file write enable
//   alu_src_b[1:0] 00 = B, 01 = 4, 10 = sign-ext imm, 11 = imm<<2
//   pc_src[1:0]    00 = ALU result, 01 = ALUOut, 10 = jump target
//   alu_control    010 add, 110 sub, 000 and, 001 or, 111 slt
//   illegal_instr  sticky unsupported-instruction flag
//   state_out      current state (debug)
//
// State encoding seen on state_out:
//   0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMREAD, 4 MEMWB, 5 MEMWRITE,
//   6 EXECUTE, 7 ALUWB, 8 BRANCH, 9 ADDIEX, 10 ADDIWB, 11 JUMP
//
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
    parameter int STATE_W      = 4,   // must be >= 4 to hold all states
    parameter int TRAP_ILLEGAL = 1    // 1 = flag unsupported instructions
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    output logic               mem_to_reg,
    output logic               reg_dest,
    output logic               i_or_d,
    output logic               alu_src_a,
    output logic               ir_write,
    output logic               mem_write,
    output logic               pc_write,
    output logic               branch,
    output logic               reg_write,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         pc_src,
    output logic [2:0]         alu_control,
    output logic               illegal_instr,
    output logic [STATE_W-1:0] state_out
);

    // ------------------------------------------------------------------
    // Opcode / funct constants
    // ------------------------------------------------------------------
    localparam logic [5:0] C_OP_R    = 6'b000000;
    localparam logic [5:0] C_OP_LW   = 6'b100011;
    localparam logic [5:0] C_OP_SW   = 6'b101011;
    localparam logic [5:0] C_OP_BEQ  = 6'b000100;
    localparam logic [5:0] C_OP_ADDI = 6'b001000;
    localparam logic [5:0] C_OP_J    = 6'b000010;

    localparam logic [5:0] C_FN_ADD  = 6'b100000;
    localparam logic [5:0] C_FN_SUB  = 6'b100010;
    localparam logic [5:0] C_FN_AND  = 6'b100100;
    localparam logic [5:0] C_FN_OR   = 6'b100101;
    localparam logic [5:0] C_FN_SLT  = 6'b101010;

    localparam logic [1:0] C_ALUOP_ADD   = 2'b00;
    localparam logic [1:0] C_ALUOP_SUB   = 2'b01;
    localparam logic [1:0] C_ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] C_ALU_ADD = 3'b010;
    localparam logic [2:0] C_ALU_SUB = 3'b110;
    localparam logic [2:0] C_ALU_AND = 3'b000;
    localparam logic [2:0] C_ALU_OR  = 3'b001;
    localparam logic [2:0] C_ALU_SLT = 3'b111;

    // ------------------------------------------------------------------
    // State type
    // ------------------------------------------------------------------
    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = STATE_W'(0),
        S_DECODE   = STATE_W'(1),
        S_MEMADR   = STATE_W'(2),
        S_MEMREAD  = STATE_W'(3),
        S_MEMWB    = STATE_W'(4),
        S_MEMWRITE = STATE_W'(5),
        S_EXECUTE  = STATE_W'(6),
        S_ALUWB    = STATE_W'(7),
        S_BRANCH   = STATE_W'(8),
        S_ADDIEX   = STATE_W'(9),
        S_ADDIWB   = STATE_W'(10),
        S_JUMP     = STATE_W'(11)
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [1:0] w_alu_op;
    logic       w_opcode_ok;
    logic       w_funct_ok;
    logic       w_set_illegal;

    // ------------------------------------------------------------------
    // Instruction classification
    // ------------------------------------------------------------------
    always_comb begin
        w_opcode_ok = 1'b0;
        case (opcode)
            C_OP_R, C_OP_LW, C_OP_SW,
            C_OP_BEQ, C_OP_ADDI, C_OP_J: w_opcode_ok = 1'b1;
            default:                      w_opcode_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_funct_ok = 1'b0;
        case (funct)
            C_FN_ADD, C_FN_SUB, C_FN_AND,
            C_FN_OR, C_FN_SLT: w_funct_ok = 1'b1;
            default:           w_funct_ok = 1'b0;
        endcase
    end

    // An unsupported instruction is detected in the step that first
    // inspects the offending field: opcode in DECODE, funct in EXECUTE.
    assign w_set_illegal = ((r_state == S_DECODE)  && !w_opcode_ok) ||
                           ((r_state == S_EXECUTE) && !w_funct_ok);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    C_OP_LW, C_OP_SW: w_next = S_MEMADR;
                    C_OP_R:           w_next = S_EXECUTE;
                    C_OP_BEQ:         w_next = S_BRANCH;
                    C_OP_ADDI:        w_next = S_ADDIEX;
                    C_OP_J:           w_next = S_JUMP;
                    default:          w_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                // Only LW and SW reach this state; anything else returns
                // to FETCH rather than issuing a memory access.
                if (opcode == C_OP_LW) begin
                    w_next = S_MEMREAD;
                end else if (opcode == C_OP_SW) begin
                    w_next = S_MEMWRITE;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_MEMREAD:  w_next = S_MEMWB;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: w_next = S_FETCH;
            S_EXECUTE:  w_next = w_funct_ok ? S_ALUWB : S_FETCH;
            S_ALUWB:    w_next = S_FETCH;
            S_BRANCH:   w_next = S_FETCH;
            S_ADDIEX:   w_next = S_ADDIWB;
            S_ADDIWB:   w_next = S_FETCH;
            S_JUMP:     w_next = S_FETCH;
            default:    w_next = S_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Moore control outputs (pure functions of state)
    // ------------------------------------------------------------------
    always_comb begin
        mem_to_reg = 1'b0;
        reg_dest   = 1'b0;
        i_or_d     = 1'b0;
        alu_src_a  = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        reg_write  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        w_alu_op   = C_ALUOP_ADD;
        case (r_state)
            S_FETCH: begin
                alu_src_b = 2'b01;
                ir_write  = 1'b1;
                pc_write  = 1'b1;
            end
            S_DECODE: begin
                // Precompute the branch target while decoding.
                alu_src_b = 2'b11;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMREAD: begin
                i_or_d = 1'b1;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b00;
                w_alu_op  = C_ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_dest  = 1'b1;
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                w_alu_op  = C_ALUOP_SUB;
                pc_src    = 2'b01;
                branch    = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
            end
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // ALU decoder
    // ------------------------------------------------------------------
    always_comb begin
        alu_control = C_ALU_ADD;
        case (w_alu_op)
            C_ALUOP_ADD: alu_control = C_ALU_ADD;
            C_ALUOP_SUB: alu_control = C_ALU_SUB;
            C_ALUOP_FUNCT: begin
                case (funct)
                    C_FN_ADD: alu_control = C_ALU_ADD;
                    C_FN_SUB: alu_control = C_ALU_SUB;
                    C_FN_AND: alu_control = C_ALU_AND;
                    C_FN_OR:  alu_control = C_ALU_OR;
                    C_FN_SLT: alu_control = C_ALU_SLT;
                    default:  alu_control = C_ALU_ADD;
                endcase
            end
            default: alu_control = C_ALU_ADD;
        endcase
    end

    // ------------------------------------------------------------------
    // Sticky illegal-instruction flag
    // ------------------------------------------------------------------
    generate
        if (TRAP_ILLEGAL != 0) begin : g_trap
            logic r_illegal;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_illegal <= 1'b0;
                end else if (w_set_illegal) begin
                    r_illegal <= 1'b1;
                end
            end
            assign illegal_instr = r_illegal;
        end else begin : g_no_trap
            logic w_unused_set_illegal;
            assign w_unused_set_illegal = w_set_illegal;
            assign illegal_instr        = 1'b0;
        end
    endgenerate

    assign state_out = r_state;

endmodule
`default_nettype wire
